sync_fifo_gen: RTL and testbench
================================

# sync_fifo_gen

Single-clock, parametrised FIFO: the next generation of the team's synchronous FIFO. Supports any entry count (not only powers of two), a compile-time first-word-fall-through (FWFT) or registered-read mode, programmable almost-full/almost-empty thresholds, an occupancy output, and a synchronous flush. It sits between datapath stages that need elastic buffering with back-pressure flags.

## Interface
- G_WIDTH, 8: data width in bits, at least 1.
- G_DEPTH, 16: number of entries, any integer from 2 to 1024.
- G_FWFT, 0: 0 selects registered-read mode; 1 selects FWFT mode.
- G_AFULL, G_DEPTH-2: almost-full threshold, range 1..G_DEPTH.
- G_AEMPTY, 2: almost-empty threshold, range 0..G_DEPTH-1.
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clr  in  1  synchronous flush.
- i_wr  in  1  write request.
- i_data  in  G_WIDTH  write data.
- i_rd  in  1  read request (pop).
- o_data  out  G_WIDTH  read data.
- o_valid  out  1  read data qualifier.
- o_full, o_empty  out  1  occupancy == G_DEPTH / == 0.
- o_afull, o_aempty  out  1  level >= G_AFULL / level <= G_AEMPTY.
- o_level  out  LW  occupancy, where LW = $clog2(G_DEPTH+1).
- o_overflow, o_underflow  out  1  same-cycle rejected-write / rejected-read pulses.
- o_ovf_sticky, o_udf_sticky  out  1  latched error flags.

## Operation
- **Storage:** register array of G_DEPTH entries, with write pointer wr_ptr and read pointer rd_ptr.
  - Pointers are $clog2(G_DEPTH) bits wide.
  - Each pointer wraps explicitly from G_DEPTH-1 to 0; no power-of-two arithmetic.
  - A registered count `level` (LW bits) is the single source of all flags.
- **Read accepted:** rd_ok = i_rd && !o_empty.
- **Write accepted:** wr_ok = i_wr && (!o_full || rd_ok). Writing at full is allowed when a pop occurs in the same cycle.
- **Level update:** level increments on wr_ok && !rd_ok, decrements on rd_ok && !wr_ok, and is otherwise unchanged.
- **Simultaneous write and read at empty:**
  - The write is accepted and the read is rejected.
  - o_underflow = 1 and level becomes 1.
- **Error pulses:** o_overflow = i_wr && !wr_ok; o_underflow = i_rd && !rd_ok. Both are combinational and are forced to 0 while i_clr = 1.
- **Sticky flags:** set when the matching pulse is 1; cleared only by reset or i_clr.
- **Flush (i_clr = 1):**
  - wr_ptr, rd_ptr, level, sticky flags and o_valid go to 0 on the next edge.
  - i_wr and i_rd are ignored in that cycle.
  - Memory contents are not cleared.
- **Registered-read mode (G_FWFT = 0):**
  - On rd_ok, o_data <= mem[rd_ptr] and o_valid is 1 for exactly the next cycle.
  - o_data otherwise holds its last value.
- **FWFT mode (G_FWFT = 1):**
  - o_data = mem[rd_ptr] when !o_empty, else 0.
  - o_valid = !o_empty.
  - i_rd acts as an acknowledge of the presented word.

## Timing
- **Reset values (all outputs):**
  - o_data = 0, o_valid = 0, o_empty = 1, o_full = 0, o_afull = 0, o_aempty = 1, o_level = 0.
  - o_overflow, o_underflow, o_ovf_sticky, o_udf_sticky = 0.
- Reset mid-operation discards all contents immediately (asynchronous assertion). Release is synchronous to i_clk through the normal flop behaviour.
- **Flags:** o_full, o_empty, o_afull, o_aempty and o_level are decoded from the level register. They have no combinational path from i_wr or i_rd and update on the edge after the accepted operation.
- **Write to visibility:**
  - A write in cycle N makes o_empty = 0 in cycle N+1.
  - FWFT: o_valid = 1 with the written data in cycle N+1.
  - Registered-read: a read accepted in cycle M gives data with o_valid = 1 in cycle M+1.
- **Throughput:** one write and one read per cycle, sustained at any level, including full (with a read) and empty (with a write, after one cycle of fill).
- **Wrap-around:** after G_DEPTH accepted writes, wr_ptr returns to 0; rd_ptr behaves identically.

## Structure
- **Package fifo_pkg:**
  - function lvl_w(depth) returning $clog2(depth+1);
  - function ptr_w(depth) returning max(1, $clog2(depth));
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}.
- **Sub-module fifo_regfile:** parametrised by G_WIDTH and G_DEPTH; one synchronous write port and one asynchronous read port, no reset. The top level holds pointers, level, flags and the output stage.
- **Elaboration checks:** parameter range checks via $error.

## Test plan
- **Fill/drain, G_DEPTH = 5, G_FWFT = 0:** write 1..5 then read 5 times. o_full = 1 after the 5th write, and o_afull = 1 at level 3. Data returns 1..5, each with o_valid one cycle after the read. o_empty = 1 at the end.
- **Wrap, G_DEPTH = 5:** run 13 interleaved write/read pairs with data 0..12. Output order is preserved, both pointers pass through 4→0, and level never exceeds 1.
- **Full with simultaneous write and read:** at level 5, assert i_wr and i_rd with data 0xAA. Both are accepted, level stays 5, o_overflow = 0. The next i_wr alone gives o_overflow = 1 and o_ovf_sticky = 1.
- **Empty with simultaneous write and read, G_FWFT = 1:** i_wr = i_rd = 1 with data 0x3C. Then o_underflow = 1, o_udf_sticky = 1, and on the next cycle o_valid = 1, o_data = 0x3C, level = 1.
- **Flush:** at level 4, assert i_clr together with i_wr. Next cycle level = 0, o_empty = 1, sticky flags = 0, o_overflow = 0. The subsequently written 0x11 reads back first.
- **Asynchronous reset:** drop i_rst_n mid-cycle at level 3. All outputs take their reset values before the next edge, and after release a write/read of 0x55 returns 0x55.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and mode encoding for sync_fifo_gen
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Bits needed to hold an occupancy of 0..depth inclusive
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address depth entries, never narrower than one bit
   function automatic int ptr_w(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - storage array with one synchronous write and one asynchronous read port
module fifo_regfile
   import fifo_pkg::*;
#(
   parameter int G_WIDTH = 8,
   parameter int G_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [ptr_w(G_DEPTH)-1:0]   waddr,
   input  logic [G_WIDTH-1:0]          wdata,
   input  logic [ptr_w(G_DEPTH)-1:0]   raddr,
   output logic [G_WIDTH-1:0]          rdata
);

   logic [G_WIDTH-1:0] mem [G_DEPTH];

   // Contents are deliberately not reset; occupancy tracking decides what is valid
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// rtl/sync_fifo_gen.sv - single-clock FIFO with any depth, FWFT option, thresholds and flush
module sync_fifo_gen
   import fifo_pkg::*;
#(
   parameter int G_WIDTH  = 8,
   parameter int G_DEPTH  = 16,
   parameter int G_FWFT   = 0,
   parameter int G_AFULL  = G_DEPTH - 2,
   parameter int G_AEMPTY = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_clr,
   input  logic                        i_wr,
   input  logic [G_WIDTH-1:0]          i_data,
   input  logic                        i_rd,
   output logic [G_WIDTH-1:0]          o_data,
   output logic                        o_valid,
   output logic                        o_full,
   output logic                        o_empty,
   output logic                        o_afull,
   output logic                        o_aempty,
   output logic [lvl_w(G_DEPTH)-1:0]   o_level,
   output logic                        o_overflow,
   output logic                        o_underflow,
   output logic                        o_ovf_sticky,
   output logic                        o_udf_sticky
);

   localparam int         LW   = lvl_w(G_DEPTH);
   localparam int         PW   = ptr_w(G_DEPTH);
   localparam fifo_mode_e MODE = (G_FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   localparam logic [LW-1:0] LVL_FULL   = LW'(G_DEPTH);
   localparam logic [LW-1:0] LVL_AFULL  = LW'(G_AFULL);
   localparam logic [LW-1:0] LVL_AEMPTY = LW'(G_AEMPTY);
   localparam logic [PW-1:0] PTR_LAST   = PW'(G_DEPTH - 1);

   // Reject illegal parameter sets at elaboration
   generate
      if (G_WIDTH < 1) begin : g_chk_width
         $error("sync_fifo_gen: G_WIDTH must be at least 1");
      end
      if (G_DEPTH < 2 || G_DEPTH > 1024) begin : g_chk_depth
         $error("sync_fifo_gen: G_DEPTH must be in 2..1024");
      end
      if (G_FWFT != 0 && G_FWFT != 1) begin : g_chk_fwft
         $error("sync_fifo_gen: G_FWFT must be 0 or 1");
      end
      if (G_AFULL < 1 || G_AFULL > G_DEPTH) begin : g_chk_afull
         $error("sync_fifo_gen: G_AFULL must be in 1..G_DEPTH");
      end
      if (G_AEMPTY < 0 || G_AEMPTY > G_DEPTH - 1) begin : g_chk_aempty
         $error("sync_fifo_gen: G_AEMPTY must be in 0..G_DEPTH-1");
      end
   endgenerate

   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr_nxt;
   logic [PW-1:0]      rd_ptr_nxt;
   logic [LW-1:0]      level;
   logic               empty;
   logic               full;
   logic               rd_ok;
   logic               wr_ok;
   logic               overflow;
   logic               underflow;
   logic               ovf_sticky;
   logic               udf_sticky;
   logic [G_WIDTH-1:0] rd_word;

   // All flags come from the level register only, so no input reaches them combinationally
   assign empty = (level == '0);
   assign full  = (level == LVL_FULL);

   // A flush cycle swallows both requests; a pop frees the slot a write at full needs
   assign rd_ok     = !i_clr && i_rd && !empty;
   assign wr_ok     = !i_clr && i_wr && (!full || rd_ok);
   assign overflow  = !i_clr && i_wr && !wr_ok;
   assign underflow = !i_clr && i_rd && !rd_ok;

   // Explicit wrap keeps non-power-of-two depths correct
   assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
   assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (i_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr_nxt;
         end
         if (wr_ok && !rd_ok) begin
            level <= level + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            level <= level - 1'b1;
         end
      end
   end

   // Latch rejected operations until reset or flush
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovf_sticky <= 1'b0;
         udf_sticky <= 1'b0;
      end else if (i_clr) begin
         ovf_sticky <= 1'b0;
         udf_sticky <= 1'b0;
      end else begin
         if (overflow) begin
            ovf_sticky <= 1'b1;
         end
         if (underflow) begin
            udf_sticky <= 1'b1;
         end
      end
   end

   fifo_regfile #(
      .G_WIDTH (G_WIDTH),
      .G_DEPTH (G_DEPTH)
   ) u_regfile (
      .clk   (i_clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (i_data),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   generate
      if (MODE == FIFO_FWFT) begin : g_fwft
         // Head word is presented directly; zero when nothing is stored
         assign o_data  = empty ? '0 : rd_word;
         assign o_valid = !empty;
      end else begin : g_std
         logic [G_WIDTH-1:0] data_q;
         logic               valid_q;

         // Registered read: popped word appears with a one-cycle valid strobe
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else if (i_clr) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_ok;
               if (rd_ok) begin
                  data_q <= rd_word;
               end
            end
         end

         assign o_data  = data_q;
         assign o_valid = valid_q;
      end
   endgenerate

   assign o_full       = full;
   assign o_empty      = empty;
   assign o_afull      = (level >= LVL_AFULL);
   assign o_aempty     = (level <= LVL_AEMPTY);
   assign o_level      = level;
   assign o_overflow   = overflow;
   assign o_underflow  = underflow;
   assign o_ovf_sticky = ovf_sticky;
   assign o_udf_sticky = udf_sticky;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// tb/tb_sync_fifo_gen.sv - directed self-checking bench for sync_fifo_gen in both read modes
module tb_sync_fifo_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic [7:0] din = 8'h00;

   logic [7:0] s_data, f_data;
   logic       s_valid, f_valid, s_full, f_full, s_empty, f_empty;
   logic       s_afull, f_afull, s_aempty, f_aempty;
   logic [2:0] s_level, f_level;
   logic       s_ovf, f_ovf, s_udf, f_udf, s_ovfs, f_ovfs, s_udfs, f_udfs;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   sync_fifo_gen #(.G_WIDTH(8), .G_DEPTH(5), .G_FWFT(0)) u_std (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr(wr), .i_data(din), .i_rd(rd),
      .o_data(s_data), .o_valid(s_valid), .o_full(s_full), .o_empty(s_empty),
      .o_afull(s_afull), .o_aempty(s_aempty), .o_level(s_level),
      .o_overflow(s_ovf), .o_underflow(s_udf), .o_ovf_sticky(s_ovfs), .o_udf_sticky(s_udfs)
   );

   sync_fifo_gen #(.G_WIDTH(8), .G_DEPTH(5), .G_FWFT(1)) u_fwft (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr(wr), .i_data(din), .i_rd(rd),
      .o_data(f_data), .o_valid(f_valid), .o_full(f_full), .o_empty(f_empty),
      .o_afull(f_afull), .o_aempty(f_aempty), .o_level(f_level),
      .o_overflow(f_ovf), .o_underflow(f_udf), .o_ovf_sticky(f_ovfs), .o_udf_sticky(f_udfs)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state();
      check("rst_s_data", s_data, 0);
      check("rst_s_valid", s_valid, 0);
      check("rst_s_empty", s_empty, 1);
      check("rst_s_full", s_full, 0);
      check("rst_s_afull", s_afull, 0);
      check("rst_s_aempty", s_aempty, 1);
      check("rst_s_level", s_level, 0);
      check("rst_s_ovf", s_ovf, 0);
      check("rst_s_udf", s_udf, 0);
      check("rst_s_ovfs", s_ovfs, 0);
      check("rst_s_udfs", s_udfs, 0);
      check("rst_f_data", f_data, 0);
      check("rst_f_valid", f_valid, 0);
      check("rst_f_level", f_level, 0);
      check("rst_f_udfs", f_udfs, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      check_reset_state();
      rst_n = 1'b1;
      tick();

      // fill 1..5
      for (int i = 1; i <= 5; i++) begin
         wr = 1'b1;
         din = 8'(i);
         #1 check("fill_ovf", s_ovf, 0);
         tick();
         check("fill_level", s_level, i);
         check("fill_f_level", f_level, i);
         check("fill_full", s_full, (i == 5));
         check("fill_afull", s_afull, (i >= 3));
         check("fill_aempty", s_aempty, (i <= 2));
         check("fill_empty", s_empty, 0);
         check("fill_f_valid", f_valid, 1);
         check("fill_f_data", f_data, 1);
      end
      wr = 1'b0;
      check("fill_s_valid", s_valid, 0);

      // drain 1..5
      for (int i = 1; i <= 5; i++) begin
         rd = 1'b1;
         check("drain_f_head", f_data, i);
         tick();
         check("drain_s_valid", s_valid, 1);
         check("drain_s_data", s_data, i);
         check("drain_level", s_level, 5 - i);
      end
      rd = 1'b0;
      tick();
      check("drain_s_valid_drop", s_valid, 0);
      check("drain_empty", s_empty, 1);
      check("drain_f_valid", f_valid, 0);
      check("drain_f_data", f_data, 0);
      check("drain_udfs", s_udfs, 0);

      // wrap: 13 write/read pairs
      for (int i = 0; i < 13; i++) begin
         wr = 1'b1;
         din = 8'(i);
         tick();
         wr = 1'b0;
         check("wrap_level1", s_level, 1);
         check("wrap_f_data", f_data, i);
         rd = 1'b1;
         tick();
         rd = 1'b0;
         check("wrap_s_data", s_data, i);
         check("wrap_s_valid", s_valid, 1);
         check("wrap_level0", s_level, 0);
      end
      check("wrap_udfs", s_udfs, 0);

      // full with simultaneous write and read
      for (int i = 0; i < 5; i++) begin
         wr = 1'b1;
         din = 8'h20 + 8'(i);
         tick();
      end
      wr = 1'b0;
      check("full_flag", s_full, 1);
      check("full_level", s_level, 5);
      wr = 1'b1;
      rd = 1'b1;
      din = 8'hAA;
      #1 check("full_wr_rd_ovf", s_ovf, 0);
      check("full_wr_rd_f_ovf", f_ovf, 0);
      tick();
      check("full_wr_rd_level", s_level, 5);
      check("full_wr_rd_s_data", s_data, 8'h20);
      check("full_wr_rd_f_head", f_data, 8'h21);
      rd = 1'b0;
      din = 8'hBB;
      #1 check("full_ovf_pulse", s_ovf, 1);
      check("full_f_ovf_pulse", f_ovf, 1);
      tick();
      wr = 1'b0;
      check("full_ovfs", s_ovfs, 1);
      check("full_f_ovfs", f_ovfs, 1);
      check("full_level_hold", s_level, 5);
      #1 check("full_ovf_gone", s_ovf, 0);

      // flush at level 4 with a concurrent write
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("pre_clr_level", s_level, 4);
      check("pre_clr_s_data", s_data, 8'h21);
      clr = 1'b1;
      wr = 1'b1;
      din = 8'h77;
      #1 check("clr_ovf", s_ovf, 0);
      tick();
      clr = 1'b0;
      wr = 1'b0;
      check("clr_level", s_level, 0);
      check("clr_empty", s_empty, 1);
      check("clr_ovfs", s_ovfs, 0);
      check("clr_s_valid", s_valid, 0);
      check("clr_f_valid", f_valid, 0);
      wr = 1'b1;
      din = 8'h11;
      tick();
      wr = 1'b0;
      check("clr_f_first", f_data, 8'h11);
      check("clr_level1", f_level, 1);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("clr_s_first", s_data, 8'h11);
      check("clr_s_valid1", s_valid, 1);

      // empty with simultaneous write and read
      wr = 1'b1;
      rd = 1'b1;
      din = 8'h3C;
      #1 check("emp_udf", f_udf, 1);
      check("emp_s_udf", s_udf, 1);
      check("emp_ovf", f_ovf, 0);
      tick();
      wr = 1'b0;
      rd = 1'b0;
      check("emp_udfs", f_udfs, 1);
      check("emp_f_valid", f_valid, 1);
      check("emp_f_data", f_data, 8'h3C);
      check("emp_level", f_level, 1);
      check("emp_s_valid", s_valid, 0);
      #1 check("emp_udf_gone", f_udf, 0);

      // asynchronous reset at level 3
      for (int i = 1; i <= 3; i++) begin
         wr = 1'b1;
         din = 8'(i);
         tick();
      end
      wr = 1'b0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("pre_rst_level", s_level, 3);
      check("pre_rst_afull", s_afull, 1);
      check("pre_rst_s_data", s_data, 8'h3C);
      #3 rst_n = 1'b0;
      #1 check_reset_state();
      @(posedge clk);
      #1 rst_n = 1'b1;
      wr = 1'b1;
      din = 8'h55;
      tick();
      wr = 1'b0;
      check("post_rst_f_data", f_data, 8'h55);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check("post_rst_s_data", s_data, 8'h55);
      check("post_rst_s_valid", s_valid, 1);
      check("post_rst_empty", s_empty, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
